aes_core_arbiter: RTL and testbench

- Shares one iterative AES-128 core between two requesters.
  - Requester 0: the password path, which encrypts new passwords and decrypts stored ones.
  - Requester 1: the boot/maintenance path, which runs master-key and flash-record operations.
- Two-way round-robin arbitration, one operation in flight at a time.
- Captures operands, sequences the core with a start/done handshake, and routes the result back to the granted requester.
- Adds a watchdog so a core that never asserts done cannot hang the Pass-Keeper controller.

---
 rtl/aes_core_arbiter_pkg.sv | 7 +
 rtl/aes_core_arbiter_rr.sv | 15 +
 rtl/aes_core_arbiter.sv | 105 ++++++++++
 tb/tb_aes_core_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/aes_core_arbiter_pkg.sv
// pk_aes_arb: shared state encoding and constants for the AES core arbiter
package pk_aes_arb;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;
    localparam int TIMEOUT_DEF = 64;
endpackage

// File: rtl/aes_core_arbiter_rr.sv
// rr_arbiter2: two-way round-robin grant whose history advances only on accept
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic       grant,
    output logic       last_grant
);
    assign grant = &req ? ~last_grant : req[1];
    // Remember the last winner; the reset value lets requester 0 win the first tie
    always_ff @(posedge clk or negedge rst)
        if (!rst) last_grant <= 1'b1;
        else if (en) last_grant <= grant;
endmodule

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: shares one iterative AES core between two requesters with a done watchdog
module aes_core_arbiter
    import pk_aes_arb::*;
#(
    parameter int DATA_W  = 128,
    parameter int KEY_W   = 128,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_mode,
    input  logic [KEY_W-1:0]  req0_key,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic              rsp0_err,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    input  logic              req1_mode,
    input  logic [KEY_W-1:0]  req1_key,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic              rsp1_err,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              core_start,
    output logic              core_mode,
    output logic [KEY_W-1:0]  core_key,
    output logic [DATA_W-1:0] core_data,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic              busy
);
    state_t            state, state_nx;
    logic              idle, grant, last_grant, accept, tmo, finish, err_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] res;

    assign idle   = state == IDLE;
    assign accept = idle & (grant ? req1_valid : req0_valid);
    assign tmo    = cnt == CNT_W'(TIMEOUT - 1);
    assign finish = (state == WAIT) & (core_done | tmo);
    assign res    = core_done ? core_result : '0;

    rr_arbiter2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        ({req1_valid & idle, req0_valid & idle}),
        .en         (accept),
        .grant      (grant),
        .last_grant (last_grant)
    );

    // Ready is held low while reset is asserted so nothing is offered during reset
    assign req0_ready = rst & idle & ~grant;
    assign req1_ready = rst & idle & grant;
    assign core_start = state == ISSUE;
    assign busy       = ~idle;
    assign rsp0_valid = (state == RESP) & ~last_grant;
    assign rsp1_valid = (state == RESP) & last_grant;
    assign rsp0_err   = err_q;
    assign rsp1_err   = err_q;

    // State register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;

    // Next state: done wins over a timeout landing in the same cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = finish ? RESP : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, watchdog counting and per-port result registers
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            core_mode <= 1'b0;
            core_key  <= '0;
            core_data <= '0;
            cnt       <= '0;
            err_q     <= 1'b0;
            rsp0_data <= '0;
            rsp1_data <= '0;
        end else begin
            if (accept) begin
                core_mode <= grant ? req1_mode : req0_mode;
                core_key  <= grant ? req1_key : req0_key;
                core_data <= grant ? req1_data : req0_data;
            end
            cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (finish) begin
                err_q <= ~core_done;
                if (last_grant) rsp1_data <= res;
                else rsp0_data <= res;
            end
        end
endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter: directed vector bench with a behavioural AES core model
module tb_aes_core_arbiter;
    localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic         v0, v1, m0, m1;
        logic [127:0] k0, d0, k1, d1;
        int           lat;
        logic         hang, keep, g;
        int           elat;
        logic         err;
        logic [127:0] res;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0;
    logic req0_valid = 1'b0, req0_mode = 1'b0, req1_valid = 1'b0, req1_mode = 1'b0;
    logic [127:0] req0_key = '0, req0_data = '0, req1_key = '0, req1_data = '0;
    logic req0_ready, rsp0_valid, rsp0_err, req1_ready, rsp1_valid, rsp1_err;
    logic [127:0] rsp0_data, rsp1_data, core_key, core_data;
    logic core_start, core_mode, busy;
    logic core_done = 1'b0;
    logic [127:0] core_result = '0;

    int n_chk = 0, n_fail = 0;
    int lat = 1, ctr = 0;
    logic hang = 1'b0, inject = 1'b0;
    logic [127:0] res_m = '0;
    vec_t tv[10];

    aes_core_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_mode(req0_mode), .req0_key(req0_key), .req0_data(req0_data),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_mode(req1_mode), .req1_key(req1_key), .req1_data(req1_data),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err), .rsp1_data(rsp1_data),
        .core_start(core_start), .core_mode(core_mode), .core_key(core_key), .core_data(core_data),
        .core_done(core_done), .core_result(core_result), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in cipher: the FIPS-197 vector both ways, a simple xor mix otherwise
    function automatic logic [127:0] aes_m(input logic m, input logic [127:0] k, input logic [127:0] d);
        if (k == K && !m && d == PT) return CT;
        if (k == K && m && d == CT) return PT;
        return d ^ k ^ {128{m}};
    endfunction

    function automatic vec_t mk(input logic v0, input logic v1, input logic m0, input logic m1,
                                input logic [127:0] k0, input logic [127:0] d0,
                                input logic [127:0] k1, input logic [127:0] d1, input int l,
                                input logic h, input logic kp, input logic g, input int el,
                                input logic e, input logic [127:0] r);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.m0 = m0; v.m1 = m1; v.k0 = k0; v.d0 = d0; v.k1 = k1; v.d1 = d1;
        v.lat = l; v.hang = h; v.keep = kp; v.g = g; v.elat = el; v.err = e; v.res = r;
        return v;
    endfunction

    // Core model: done pulses L cycles after the start cycle, aborts on reset
    always @(negedge clk) begin
        core_done = 1'b0;
        if (!rst) ctr = 0;
        else if (ctr > 0) begin
            ctr--;
            if (ctr == 0) begin
                core_done   = 1'b1;
                core_result = res_m;
            end
        end
        if (inject) begin
            core_done   = 1'b1;
            core_result = 128'hdead;
            inject      = 1'b0;
        end
        if (rst && core_start && !hang) begin
            ctr   = lat;
            res_m = aes_m(core_mode, core_key, core_data);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        logic g, got;
        req0_valid = v.v0; req0_mode = v.m0; req0_key = v.k0; req0_data = v.d0;
        req1_valid = v.v1; req1_mode = v.m1; req1_key = v.k1; req1_data = v.d1;
        lat = v.lat; hang = v.hang;
        got = 1'b0; g = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) begin got = 1'b1; g = 1'b0; end
            else if (req1_valid && req1_ready) begin got = 1'b1; g = 1'b1; end
        end
        check("accept", 128'(got), 128'(1'b1));
        check("grant", 128'(g), 128'(v.g));
        @(posedge clk); #1;
        if (!v.keep) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        check("core_start", 128'(core_start), 128'(1'b1));
        check("core_mode", 128'(core_mode), 128'(g ? v.m1 : v.m0));
        check("core_data", core_data, g ? v.d1 : v.d0);
        check("core_key", core_key, g ? v.k1 : v.k0);
        check("busy", 128'(busy), 128'(1'b1));
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(rsp0_valid || rsp1_valid) && n < 80);
        check("latency", 128'(n), 128'(v.elat));
        check("rsp_port", 128'({rsp1_valid, rsp0_valid}), 128'(g ? 2'b10 : 2'b01));
        check("rsp_data", g ? rsp1_data : rsp0_data, v.res);
        check("rsp_err", 128'(g ? rsp1_err : rsp0_err), 128'(v.err));
        @(posedge clk); #1;
        check("rsp_pulse", 128'({rsp1_valid, rsp0_valid}), 128'(2'b00));
        check("busy_drop", 128'(busy), 128'(1'b0));
    endtask

    initial begin
        int spur;
        tv[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, K, PT, '0, '0, 10, 1'b0, 1'b0, 1'b0, 11, 1'b0, CT);
        tv[1] = mk(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, K, CT, 3, 1'b0, 1'b0, 1'b1, 4, 1'b0, PT);
        tv[2] = mk(1'b1, 1'b1, 1'b0, 1'b0, '0, 128'h1111, 128'h000f, 128'h00f0, 1, 1'b0, 1'b1, 1'b0, 2, 1'b0, 128'h1111);
        tv[3] = mk(1'b1, 1'b1, 1'b0, 1'b0, '0, 128'h1111, 128'h000f, 128'h00f0, 1, 1'b0, 1'b1, 1'b1, 2, 1'b0, 128'h00ff);
        tv[4] = mk(1'b1, 1'b1, 1'b0, 1'b0, '0, 128'h1111, 128'h000f, 128'h00f0, 1, 1'b0, 1'b1, 1'b0, 2, 1'b0, 128'h1111);
        tv[5] = mk(1'b1, 1'b1, 1'b0, 1'b0, '0, 128'h1111, 128'h000f, 128'h00f0, 1, 1'b0, 1'b0, 1'b1, 2, 1'b0, 128'h00ff);
        tv[6] = mk(1'b1, 1'b0, 1'b0, 1'b0, K, 128'h42, '0, '0, 1, 1'b1, 1'b0, 1'b0, 65, 1'b1, '0);
        tv[7] = mk(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, '0, '0, 2, 1'b0, 1'b0, 1'b0, 3, 1'b0, '1);
        tv[8] = mk(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, 128'h5a, 64, 1'b0, 1'b0, 1'b1, 65, 1'b0, 128'h5a);
        tv[9] = mk(1'b1, 1'b1, 1'b0, 1'b0, '0, 128'h1111, 128'h000f, 128'h00f0, 1, 1'b0, 1'b0, 1'b0, 2, 1'b0, 128'h1111);

        req0_valid = 1'b1;
        #12;
        check("rst_ready0", 128'(req0_ready), 128'(1'b0));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_start", 128'(core_start), 128'(1'b0));
        check("rst_outs", 128'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}), 128'(4'b0000));
        check("rst_data", rsp0_data | rsp1_data | core_key | core_data, '0);
        req0_valid = 1'b0;
        @(negedge clk); rst = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(tv[i]);

        inject = 1'b1;
        spur = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp0_valid || rsp1_valid || busy) spur++;
        end
        check("idle_done_ignored", 128'(spur), 128'(0));

        lat = 10; hang = 1'b0;
        req0_valid = 1'b1; req0_mode = 1'b0; req0_key = 128'h77; req0_data = 128'h99;
        for (int i = 0; i < 20 && !(req0_ready && req0_valid); i++) @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        req0_valid = 1'b1;
        #1;
        check("mid_rst_busy", 128'({busy, core_start, req0_ready, rsp0_valid, rsp1_valid}), 128'(5'b0));
        check("mid_rst_regs", 128'(|{core_key, core_data, rsp0_data, rsp1_data}), 128'(1'b0));
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        spur = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (rsp0_valid || rsp1_valid || busy) spur++;
        end
        check("no_stale_rsp", 128'(spur), 128'(0));
        run_vec(tv[9]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
